// File: rtl/audio_stream_gain_if.sv
// Stream, control and volume-handshake signals of the audio gain stage.
// The master side feeds samples and control; the slave side is the gain block.
interface audio_stream_gain_if #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 7
);
  logic                         in_valid;
  logic [CHANNELS*SAMPLE_W-1:0] in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic [CHANNELS*SAMPLE_W-1:0] out_data;
  logic                         out_ready;
  logic                         play;
  logic                         mute;
  logic [CHANNELS*GAIN_W-1:0]   vol_target;
  logic                         vol_set;
  logic                         vol_ack;
  logic                         vol_busy;

  modport master (
    output in_valid, in_data, out_ready, play, mute, vol_target, vol_set,
    input  in_ready, out_valid, out_data, vol_ack, vol_busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, play, mute, vol_target, vol_set,
    output in_ready, out_valid, out_data, vol_ack, vol_busy
  );
endinterface

// File: rtl/audio_stream_gain.sv
// Multichannel gain stage: two-stage multiply / shift-saturate pipeline,
// per-channel click-free gain ramping, mute, play/pause gating and a
// four-phase set/acknowledge volume update port.
module audio_stream_gain #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 7,
  parameter int RAMP_DIV = 64
) (
  input logic              clk_clk,
  input logic              reset_reset_n,
  audio_stream_gain_if.slave bus
);

  localparam int DATA_W = CHANNELS * SAMPLE_W;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int CNT_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [GAIN_W-1:0]        UNITY   = {1'b1, {(GAIN_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] SAT_MAX = {{(GAIN_W+2){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } vol_state_e;

  // Pipeline
  logic                     w_en;
  logic                     w_accept;
  logic                     r_s1_valid;
  logic signed [PROD_W-1:0] r_s1_prod [CHANNELS];
  logic signed [PROD_W-1:0] w_prod    [CHANNELS];
  logic [DATA_W-1:0]        w_out_word;
  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_out_data;

  // Gain control
  logic [GAIN_W-1:0]   r_cur_gain [CHANNELS];
  logic [GAIN_W-1:0]   r_tgt      [CHANNELS];
  logic [GAIN_W-1:0]   w_eff_tgt  [CHANNELS];
  logic [CHANNELS-1:0] w_gain_diff;
  logic [CNT_W-1:0]    r_ramp_cnt;
  logic                w_tick;
  vol_state_e          r_vol_state;
  logic                r_vol_ack;
  logic                r_vol_busy;

  // Both stages advance together whenever the output register is free.
  assign w_en     = !r_out_valid | bus.out_ready;
  // Reset is folded in so the block never advertises readiness while held in reset.
  assign bus.in_ready = reset_reset_n & bus.play & w_en;
  assign w_accept = bus.in_valid & bus.in_ready;

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.vol_ack   = r_vol_ack;
  assign bus.vol_busy  = r_vol_busy;

  assign w_tick = (r_ramp_cnt == CNT_W'(RAMP_DIV - 1));

  // Per-channel arithmetic: signed x unsigned product, then floor shift and clamp.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [SAMPLE_W-1:0] w_sample;
    logic signed [PROD_W-1:0]   w_sample_ext;
    logic signed [PROD_W-1:0]   w_gain_ext;
    logic signed [PROD_W-1:0]   w_shifted;

    assign w_sample     = bus.in_data[c*SAMPLE_W +: SAMPLE_W];
    assign w_sample_ext = {{(GAIN_W+1){w_sample[SAMPLE_W-1]}}, w_sample};
    assign w_gain_ext   = {{(SAMPLE_W+1){1'b0}}, r_cur_gain[c]};
    assign w_prod[c]    = w_sample_ext * w_gain_ext;

    assign w_shifted = r_s1_prod[c] >>> (GAIN_W - 1);
    assign w_out_word[c*SAMPLE_W +: SAMPLE_W] =
      (w_shifted > SAT_MAX) ? SAT_MAX[SAMPLE_W-1:0] :
      (w_shifted < SAT_MIN) ? SAT_MIN[SAMPLE_W-1:0] :
                              w_shifted[SAMPLE_W-1:0];

    assign w_eff_tgt[c]   = bus.mute ? '0 : r_tgt[c];
    assign w_gain_diff[c] = (r_cur_gain[c] != w_eff_tgt[c]);
  end

  // S1: capture the products using the gain current in the acceptance cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      // NOTE: sequential state is written with <= so every flop samples pre-edge values, independent of block order.
      r_s1_valid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        // NOTE: this per-channel array is a few flops, not a RAM, so it is reset with the rest to keep outputs deterministic.
        r_s1_prod[c] <= '0;
      end
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        for (int c = 0; c < CHANNELS; c++) begin
          r_s1_prod[c] <= w_prod[c];
        end
      end
    end
  end

  // S2: shifted and saturated word; holds while the consumer stalls.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_out_word;
      end
    end
  end

  // Free-running ramp divider producing one tick every RAMP_DIV cycles.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_ramp_cnt <= '0;
    end else if (w_tick) begin
      r_ramp_cnt <= '0;
    end else begin
      r_ramp_cnt <= r_ramp_cnt + CNT_W'(1);
    end
  end

  // On each tick move every channel's gain one LSB toward its effective target.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_cur_gain[c] <= UNITY;
      end
    end else if (w_tick) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_cur_gain[c] < w_eff_tgt[c]) begin
          r_cur_gain[c] <= r_cur_gain[c] + GAIN_W'(1);
        end else if (r_cur_gain[c] > w_eff_tgt[c]) begin
          r_cur_gain[c] <= r_cur_gain[c] - GAIN_W'(1);
        end
      end
    end
  end

  // Four-phase volume handshake; the target is latched once, on entry to ACK.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_vol_state <= ST_IDLE;
      r_vol_ack   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_tgt[c] <= UNITY;
      end
    end else begin
      case (r_vol_state)
        ST_IDLE: begin
          if (bus.vol_set) begin
            for (int c = 0; c < CHANNELS; c++) begin
              r_tgt[c] <= bus.vol_target[c*GAIN_W +: GAIN_W];
            end
            r_vol_ack   <= 1'b1;
            r_vol_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!bus.vol_set) begin
            r_vol_ack   <= 1'b0;
            r_vol_state <= ST_IDLE;
          end
        end
        default: begin
          r_vol_ack   <= 1'b0;
          r_vol_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Busy flag: any channel still away from its effective target.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_vol_busy <= 1'b0;
    end else begin
      r_vol_busy <= |w_gain_diff;
    end
  end

endmodule

// File: tb/tb_audio_stream_gain.sv
// Scoreboard bench for audio_stream_gain: stimulus pushes reference results,
// an independent monitor pops and compares whenever an output word is taken.
module tb_audio_stream_gain;

  localparam int CH = 2;
  localparam int SW = 16;
  localparam int GW = 7;
  localparam int RD = 4;
  localparam int DW = CH * SW;

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
    bit            chk_lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  audio_stream_gain_if #(.CHANNELS(CH), .SAMPLE_W(SW), .GAIN_W(GW)) bus ();

  audio_stream_gain #(
    .CHANNELS(CH), .SAMPLE_W(SW), .GAIN_W(GW), .RAMP_DIV(RD)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .bus          (bus)
  );

  exp_t sb[$];
  int   ramp_obs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   probe_mode = 1'b0;
  int   ready_mode = 0;
  int   tgt_m[CH] = '{64, 64};
  bit   mute_m = 1'b0;
  int   busy_cnt = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h (%0d), expected 'h%0h (%0d) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: floor(sample * gain / 2^(GW-1)), clamped to the sample range.
  function automatic logic [SW-1:0] ref_ch(input int s, input int g);
    longint p, q;
    p = longint'(s) * g;
    q = p / 64;
    if (p < 0 && (p % 64) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return SW'(q);
  endfunction

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] w);
    logic [DW-1:0]        r;
    logic signed [SW-1:0] s;
    int                   g;
    for (int c = 0; c < CH; c++) begin
      s = w[c*SW +: SW];
      g = mute_m ? 0 : tgt_m[c];
      r[c*SW +: SW] = ref_ch(int'(s), g);
    end
    return r;
  endfunction

  // Downstream readiness: 0 = always ready, 1 = random, 2 = held off.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every word the consumer takes against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (probe_mode) begin
        ramp_obs.push_back(int'(bus.out_data[SW-1:0]));
      end else if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got 'h%0h, expected no word at cycle %0d", bus.out_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", bus.out_data, e.data);
        if (e.chk_lat) check("latency", cyc - e.acc, 2);
      end
    end
  end

  // Present a word (called at posedge+1); returns at posedge+1 after acceptance.
  task automatic send_word(input logic [DW-1:0] w);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{data: ref_word(w), acc: cyc, chk_lat: (ready_mode == 0)});
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 300 cycles");
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_settle();
    repeat (3) @(posedge clk);
    for (int i = 0; i < 2000 && bus.vol_busy; i++) @(negedge clk);
    check("settle_busy", bus.vol_busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Full four-phase update; the target is scrambled while ACK is high and must be ignored.
  task automatic set_vol(input int g0, input int g1);
    @(posedge clk); #1;
    bus.vol_target = {GW'(g1), GW'(g0)};
    bus.vol_set    = 1'b1;
    @(negedge clk);
    check("ack_before_rise", bus.vol_ack, 0);
    @(posedge clk); #1;
    check("ack_rise", bus.vol_ack, 1);
    bus.vol_target = {GW'(g1 ^ 'h15), GW'(g0 ^ 'h2a)};
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    bus.vol_set = 1'b0;
    @(negedge clk);
    check("ack_hold", bus.vol_ack, 1);
    @(posedge clk); #1;
    check("ack_fall", bus.vol_ack, 0);
    tgt_m[0] = g0;
    tgt_m[1] = g1;
  endtask

  initial begin
    int cnt[65];
    int bad;
    logic [DW-1:0] w0, w1, w2;

    bus.in_valid   = 1'b1;
    bus.in_data    = 32'h1234_5678;
    bus.play       = 1'b1;
    bus.mute       = 1'b0;
    bus.vol_set    = 1'b0;
    bus.vol_target = '0;

    // Reset state
    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_vol_ack", bus.vol_ack, 0);
    check("rst_vol_busy", bus.vol_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Unity pass-through, then back-to-back words
    send_word({16'hFC18, 16'd1000});
    for (int i = 0; i < 6; i++) send_word($urandom);
    idle();
    drain();

    // Gain 127 saturation, then gain 32 / gain 1
    set_vol(127, 127);
    wait_settle();
    send_word({16'h8000, 16'h7FFF});
    send_word({16'h7FFF, 16'h8000});
    for (int i = 0; i < 4; i++) send_word($urandom);
    idle();
    drain();
    set_vol(32, 1);
    wait_settle();
    send_word({16'hFFFF, 16'd1000});
    send_word({16'hFFFF, 16'hFFFF});
    idle();
    drain();

    // Ramp unity -> 0, observed through a probe value of 64 (output equals gain)
    set_vol(64, 64);
    wait_settle();
    probe_mode   = 1'b1;
    bus.in_data  = {16'd64, 16'd64};
    bus.in_valid = 1'b1;
    busy_cnt     = 0;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          @(negedge clk);
          if (bus.vol_busy) busy_cnt++;
        end
      end
      set_vol(0, 0);
    join
    idle();
    repeat (4) @(posedge clk);
    #1;
    probe_mode = 1'b0;
    check_range("ramp_busy_cycles", busy_cnt, 252, 260);
    check("ramp_first", ramp_obs[0], 64);
    check("ramp_last", ramp_obs[ramp_obs.size()-1], 0);
    foreach (cnt[v]) cnt[v] = 0;
    bad = 0;
    for (int i = 0; i < ramp_obs.size(); i++) begin
      if (ramp_obs[i] >= 0 && ramp_obs[i] <= 64) cnt[ramp_obs[i]]++;
      if (i > 0 && (ramp_obs[i-1] - ramp_obs[i]) != 0 && (ramp_obs[i-1] - ramp_obs[i]) != 1) bad++;
    end
    check("ramp_bad_steps", bad, 0);
    for (int v = 1; v < 64; v++) check($sformatf("ramp_dwell_%0d", v), cnt[v], RD);

    // Mute ramps to zero, unmute ramps back to the target
    set_vol(40, 90);
    wait_settle();
    for (int i = 0; i < 4; i++) send_word($urandom);
    idle();
    drain();
    bus.mute = 1'b1;
    mute_m   = 1'b1;
    repeat (2) @(negedge clk);
    check("mute_busy", bus.vol_busy, 1);
    wait_settle();
    for (int i = 0; i < 4; i++) send_word($urandom);
    idle();
    drain();
    bus.mute = 1'b0;
    mute_m   = 1'b0;
    wait_settle();
    for (int i = 0; i < 4; i++) send_word($urandom);
    idle();
    drain();

    // Random gains, random gaps, random backpressure
    ready_mode = 1;
    for (int b = 0; b < 4; b++) begin
      set_vol($urandom_range(0, 127), $urandom_range(0, 127));
      wait_settle();
      for (int i = 0; i < 20; i++) begin
        send_word($urandom);
        repeat ($urandom_range(0, 2)) begin
          idle();
          @(posedge clk); #1;
        end
      end
      idle();
      drain();
    end
    ready_mode = 0;

    // Stall with two words in flight
    ready_mode = 2;
    @(posedge clk); #1;
    w0 = $urandom;
    w1 = $urandom;
    w2 = $urandom;
    send_word(w0);
    send_word(w1);
    bus.in_data  = w2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_data", bus.out_data, ref_word(w0));
    end
    @(posedge clk); #1;
    ready_mode = 0;
    send_word(w2);
    idle();
    drain();

    // Pause: no acceptance, in-flight words drain
    send_word($urandom);
    send_word($urandom);
    bus.play     = 1'b0;
    bus.in_data  = $urandom;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pause_in_ready", bus.in_ready, 0);
    end
    check("pause_drained", sb.size(), 0);
    @(posedge clk); #1;
    idle();
    bus.play = 1'b1;

    // Reset mid-stream with an open handshake
    bus.vol_target = {GW'(tgt_m[1]), GW'(tgt_m[0])};
    bus.vol_set    = 1'b1;
    @(posedge clk); #1;
    send_word($urandom);
    send_word($urandom);
    send_word($urandom);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_vol_ack", bus.vol_ack, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    sb.delete();
    idle();
    bus.vol_set = 1'b0;
    tgt_m[0] = 64;
    tgt_m[1] = 64;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_word({16'd64, 16'd64});
    send_word({16'hFC18, 16'd1000});
    for (int i = 0; i < 4; i++) send_word($urandom);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
